// File: rtl/regfile_pkg.sv
// Shared widths and types for the scoreboarded register file.
package regfile_pkg;
   localparam int unsigned ADDR_WIDTH = 5;
   localparam int unsigned REG_DATA_W = 32;

   typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
   typedef logic [REG_DATA_W-1:0] reg_data_t;
endpackage : regfile_pkg

// File: rtl/regfile_sb_scoreboard.sv
// Pending-bit scoreboard: per-register reservation flags, live count and unreserved-write pulse.
// REGFILE_BYPASS_EN: a same-cycle write to the read index reports the port as not busy.
module regfile_sb_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
   parameter int unsigned N_RD       = 2
) (
   input  logic                       clk,
   input  logic                       ares,
   input  logic                       wen,
   input  logic [ADDR_WIDTH-1:0]      waddr,
   input  logic                       rsv_en,
   input  logic [ADDR_WIDTH-1:0]      rsv_addr,
   input  logic [N_RD*ADDR_WIDTH-1:0] raddr,
   output logic [N_RD-1:0]            rbusy,
   output logic                       wr_unres,
   output logic [ADDR_WIDTH:0]        busy_cnt
);
   localparam int unsigned NREG = 2**ADDR_WIDTH;

   logic [NREG-1:0]     pend_q, pend_d;
   logic [ADDR_WIDTH:0] cnt_q, cnt_d;
   logic                unres_q, unres_d;

   always_comb begin
      pend_d = pend_q;
      // Clear before set so a same-index reserve wins over the write's release.
      if (wen) pend_d[waddr] = 1'b0;
      if (rsv_en) pend_d[rsv_addr] = 1'b1;
      pend_d[0] = 1'b0;
      cnt_d = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         cnt_d = cnt_d + {{ADDR_WIDTH{1'b0}}, pend_d[i]};
      end
      unres_d = wen && (waddr != '0) && !pend_q[waddr];
   end

   always_ff @(posedge clk or negedge ares) begin
      if (!ares) begin
         pend_q  <= '0;
         cnt_q   <= '0;
         unres_q <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         unres_q <= unres_d;
      end
   end

   always_comb begin
      rbusy = '0;
      for (int unsigned k = 0; k < N_RD; k++) begin
         rbusy[k] = pend_q[raddr[k*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef REGFILE_BYPASS_EN
         if (wen && (waddr != '0) && (waddr == raddr[k*ADDR_WIDTH +: ADDR_WIDTH]))
            rbusy[k] = 1'b0;
`endif
      end
   end

   assign wr_unres = unres_q;
   assign busy_cnt = cnt_q;
endmodule : regfile_sb_scoreboard

// File: rtl/regfile_sb.sv
// Multi-read-port register file with x0 hardwired to zero and a pending-write scoreboard.
// REGFILE_BYPASS_EN: same-cycle write data is forwarded to matching read ports.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
   parameter int unsigned REG_DATA_W = regfile_pkg::REG_DATA_W,
   parameter int unsigned N_RD       = 2
) (
   input  logic                       clk,
   input  logic                       ares,
   input  logic                       wen,
   input  logic [ADDR_WIDTH-1:0]      waddr,
   input  logic [REG_DATA_W-1:0]      wdata,
   input  logic                       rsv_en,
   input  logic [ADDR_WIDTH-1:0]      rsv_addr,
   input  logic [N_RD*ADDR_WIDTH-1:0] raddr,
   output logic [N_RD*REG_DATA_W-1:0] rdata,
   output logic [N_RD-1:0]            rbusy,
   output logic                       wr_unres,
   output logic [ADDR_WIDTH:0]        busy_cnt
);
   localparam int unsigned NREG = 2**ADDR_WIDTH;

   logic [REG_DATA_W-1:0] regs_q [NREG];

   // Entry 0 is only ever written by reset, so it reads as zero forever.
   always_ff @(posedge clk or negedge ares) begin
      if (!ares) begin
         for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (wen && (waddr != '0)) begin
         regs_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata = '0;
      for (int unsigned k = 0; k < N_RD; k++) begin
         rdata[k*REG_DATA_W +: REG_DATA_W] = regs_q[raddr[k*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef REGFILE_BYPASS_EN
         if (wen && (waddr != '0) && (waddr == raddr[k*ADDR_WIDTH +: ADDR_WIDTH]))
            rdata[k*REG_DATA_W +: REG_DATA_W] = wdata;
`endif
      end
   end

   regfile_sb_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .N_RD       (N_RD)
   ) u_sb (
      .clk      (clk),
      .ares     (ares),
      .wen      (wen),
      .waddr    (waddr),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .raddr    (raddr),
      .rbusy    (rbusy),
      .wr_unres (wr_unres),
      .busy_cnt (busy_cnt)
   );
endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// Directed + randomized bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;
   import regfile_pkg::*;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NR = 2;
   localparam int NREG = 2**AW;

   logic            clk = 1'b0;
   logic            ares;
   logic            wen;
   logic [AW-1:0]   waddr;
   logic [DW-1:0]   wdata;
   logic            rsv_en;
   logic [AW-1:0]   rsv_addr;
   logic [NR*AW-1:0] raddr;
   logic [NR*DW-1:0] rdata;
   logic [NR-1:0]   rbusy;
   logic            wr_unres;
   logic [AW:0]     busy_cnt;

   int total = 0;
   int bad   = 0;

   reg_data_t mem  [NREG];
   bit        pend [NREG];
   bit        exp_unres;

   regfile_sb #(
      .ADDR_WIDTH (AW),
      .REG_DATA_W (DW),
      .N_RD       (NR)
   ) dut (
      .clk      (clk),
      .ares     (ares),
      .wen      (wen),
      .waddr    (waddr),
      .wdata    (wdata),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .raddr    (raddr),
      .rdata    (rdata),
      .rbusy    (rbusy),
      .wr_unres (wr_unres),
      .busy_cnt (busy_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit we, input int wa, input logic [31:0] wd,
                        input bit re, input int ra_rsv, input int r0, input int r1);
      wen      = we;
      waddr    = AW'(wa);
      wdata    = wd;
      rsv_en   = re;
      rsv_addr = AW'(ra_rsv);
      raddr    = {AW'(r1), AW'(r0)};
   endtask

   function automatic int model_count();
      int c = 0;
      for (int i = 0; i < NREG; i++) c += pend[i];
      return c;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NREG; i++) begin
         mem[i]  = '0;
         pend[i] = 1'b0;
      end
      exp_unres = 1'b0;
   endtask

   // Checks combinational reads before the edge, advances the model, checks registered outputs after.
   task automatic cycle();
      int a;
      logic [31:0] ed;
      bit eb;
      #1;
      for (int k = 0; k < NR; k++) begin
         a  = int'(raddr[k*AW +: AW]);
         ed = mem[a];
         eb = pend[a];
`ifdef REGFILE_BYPASS_EN
         if (wen && waddr != 0 && int'(waddr) == a) begin
            ed = wdata;
            eb = 1'b0;
         end
`endif
         chk($sformatf("rdata%0d[x%0d]", k, a), rdata[k*DW +: DW], ed);
         chk($sformatf("rbusy%0d[x%0d]", k, a), rbusy[k], eb);
      end
      @(posedge clk);
      exp_unres = wen && waddr != 0 && !pend[waddr];
      if (wen && waddr != 0) begin
         mem[waddr]  = wdata;
         pend[waddr] = 1'b0;
      end
      if (rsv_en && rsv_addr != 0) pend[rsv_addr] = 1'b1;
      #1;
      chk("busy_cnt", busy_cnt, model_count());
      chk("wr_unres", wr_unres, exp_unres);
   endtask

   initial begin
      model_clear();
      ares = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      #20;
      chk("rst_rdata", rdata, 0);
      chk("rst_rbusy", rbusy, 0);
      chk("rst_busy_cnt", busy_cnt, 0);
      chk("rst_wr_unres", wr_unres, 0);
      ares = 1'b1;

      // Write to x0 is dropped and never flags an unreserved write.
      drive(1, 0, 32'hDEADBEEF, 0, 0, 0, 0); cycle();
      drive(0, 0, 0, 0, 0, 0, 0);            cycle();
      chk("x0_read", rdata[DW-1:0], 0);
      chk("x0_unres", wr_unres, 0);

      // Reserve x5, then release it with a write.
      drive(0, 0, 0, 1, 5, 5, 0);            cycle();
      chk("rsv5_cnt", busy_cnt, 1);
      drive(1, 5, 32'h1234, 0, 0, 5, 5);     cycle();
      chk("rel5_cnt", busy_cnt, 0);
      chk("rel5_unres", wr_unres, 0);
      drive(0, 0, 0, 0, 0, 5, 0);            cycle();
      chk("rd5", rdata[DW-1:0], 32'h1234);

      // Unreserved write to x7: one-cycle error pulse.
      drive(1, 7, 32'hA5, 0, 0, 7, 0);       cycle();
      chk("unres7_hi", wr_unres, 1);
      drive(0, 0, 0, 0, 0, 7, 0);            cycle();
      chk("unres7_lo", wr_unres, 0);

      // Reserve x9, then reserve+write x9 together: data lands, still pending.
      drive(0, 0, 0, 1, 9, 0, 0);            cycle();
      drive(1, 9, 32'h55, 1, 9, 9, 0);       cycle();
      chk("x9_cnt", busy_cnt, 1);
      drive(0, 0, 0, 1, 9, 9, 9);            cycle();
      chk("x9_rd", rdata[DW-1:0], 32'h55);
      chk("x9_busy", rbusy, 2'b11);
      chk("x9_cnt_norsv", busy_cnt, 1);

      // Same-cycle read of a register being written.
      drive(1, 3, 32'hCAFE, 0, 0, 3, 3);     cycle();
      drive(0, 0, 0, 0, 0, 3, 0);            cycle();

      // Randomized traffic, biased to low indices so reservations collide.
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 1) == 1,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREG-1)) : int'($urandom_range(0, 7)),
               $urandom(),
               $urandom_range(0, 2) == 0,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREG-1)) : int'($urandom_range(0, 7)),
               $urandom_range(0, 7),
               $urandom_range(0, NREG-1));
         cycle();
         if (n == 200) begin
            ares = 1'b0;
            drive(0, 0, 0, 0, 0, 5, 9);
            #1;
            model_clear();
            chk("mid_rst_cnt", busy_cnt, 0);
            chk("mid_rst_unres", wr_unres, 0);
            chk("mid_rst_rdata", rdata, 0);
            chk("mid_rst_rbusy", rbusy, 0);
            @(posedge clk);
            #2;
            ares = 1'b1;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule : tb_regfile_sb
